// File: rtl/timer_ctrl.sv
// timer_ctrl: load/run/halt sequencing, prescaler, counter with one-cycle history and sticky irq status.
// The debug halt (HALT state, halt_req/halt_ack) is built only when TIMER_HALT_EN is defined.
module timer_ctrl #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 4
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             cfg_en,
    input  logic             cfg_updown,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_tdr,
    input  logic [DIV_W-1:0] cfg_div_val,
    input  logic [1:0]       int_en,
    input  logic [1:0]       int_clr,
    input  logic             halt_req,
    input  logic             ovf_trig,
    input  logic             udf_trig,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] last_cnt,
    output logic             load,
    output logic             en,
    output logic             updown,
    output logic [1:0]       trig_clr,
    output logic [1:0]       int_st,
    output logic             irq,
    output logic             halt_ack
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       int_st_q, int_st_d;
    logic             tick;

`ifdef TIMER_HALT_EN
    logic halt_in;
    assign halt_in = halt_req;
`else
    logic unused_halt_req;
    assign unused_halt_req = halt_req;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_cnt_q <= '0;
            div_cnt_q  <= '0;
            int_st_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_cnt_q <= last_cnt_d;
            div_cnt_q  <= div_cnt_d;
            int_st_q   <= int_st_d;
        end
    end

    // cfg_load overrides every other transition
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE: if (cfg_en) state_d = RUN;
                LOAD: state_d = cfg_en ? RUN : IDLE;
`ifdef TIMER_HALT_EN
                RUN: begin
                    if (halt_in)      state_d = HALT;
                    else if (!cfg_en) state_d = IDLE;
                end
                HALT: if (!halt_in) state_d = cfg_en ? RUN : IDLE;
`else
                RUN: if (!cfg_en) state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    assign tick = (state_q == RUN) && (div_cnt_q == cfg_div_val);

    // A lowered div_val leaves div_cnt above it, so it wraps through the full range before the next tick
    always_comb begin
        cnt_d      = cnt_q;
        last_cnt_d = cnt_q;
        div_cnt_d  = div_cnt_q;
        case (state_q)
            LOAD: begin
                // history takes the load value too, so no false wrap is seen
                cnt_d      = cfg_tdr;
                last_cnt_d = cfg_tdr;
                div_cnt_d  = '0;
            end
            RUN: begin
                if (tick) begin
                    div_cnt_d = '0;
                    cnt_d     = cfg_updown ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            HALT: div_cnt_d = div_cnt_q;
            default: div_cnt_d = '0;
        endcase
    end

    // set beats a simultaneous clear; pulses arriving during LOAD are stale and dropped
    always_comb begin
        int_st_d = int_st_q & ~int_clr;
        if (state_q != LOAD) begin
            int_st_d = int_st_d | {udf_trig, ovf_trig};
        end
    end

    assign cnt      = cnt_q;
    assign last_cnt = last_cnt_q;
    assign load     = (state_q == LOAD);
    assign en       = (state_q == RUN);
    assign updown   = cfg_updown;
    assign trig_clr = {2{state_q == LOAD}};
    assign int_st   = int_st_q;
    assign irq      = |(int_st_q & int_en);
`ifdef TIMER_HALT_EN
    assign halt_ack = (state_q == HALT);
`else
    assign halt_ack = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed-vector bench for timer_ctrl: each row drives one cycle of inputs and queues the
// hand-computed outputs for that cycle; a negedge monitor pops and compares.
module tb_timer_ctrl;

    logic       pclk, preset;
    logic       cfg_en, cfg_updown, cfg_load;
    logic [7:0] cfg_tdr;
    logic [3:0] cfg_div_val;
    logic [1:0] int_en, int_clr;
    logic       halt_req, ovf_trig, udf_trig;
    logic [7:0] cnt, last_cnt;
    logic       load, en, updown, halt_ack, irq;
    logic [1:0] trig_clr, int_st;

    timer_ctrl #(.CNT_W(8), .DIV_W(4)) dut (
        .pclk(pclk), .preset(preset), .cfg_en(cfg_en), .cfg_updown(cfg_updown),
        .cfg_load(cfg_load), .cfg_tdr(cfg_tdr), .cfg_div_val(cfg_div_val),
        .int_en(int_en), .int_clr(int_clr), .halt_req(halt_req),
        .ovf_trig(ovf_trig), .udf_trig(udf_trig), .cnt(cnt), .last_cnt(last_cnt),
        .load(load), .en(en), .updown(updown), .trig_clr(trig_clr),
        .int_st(int_st), .irq(irq), .halt_ack(halt_ack)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        int         row;
        logic [7:0] cnt;
        logic [7:0] last;
        logic       load;
        logic       en;
        logic       ud;
        logic [1:0] tclr;
        logic [1:0] ist;
        logic       irq;
        logic       hack;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    // flag groups {load, en, halt_ack}
    localparam logic [2:0] IDL = 3'b000, LD = 3'b100, RN = 3'b010, HT = 3'b001;
`ifdef TIMER_HALT_EN
    localparam logic [7:0] CST = 8'h11;
`else
    localparam logic [7:0] CST = 8'h12;
`endif

    logic       r_rst, r_en, r_ud, r_ld, r_hlt, r_ovf, r_udf;
    logic [7:0] r_tdr;
    logic [3:0] r_div;
    logic [1:0] r_ie, r_ic;

    task automatic step(input logic [7:0] ec, input logic [7:0] el, input logic [2:0] fl,
                        input logic [1:0] ist, input logic eirq);
        exp_t e;
        @(posedge pclk);
        #1;
        preset = r_rst; cfg_en = r_en; cfg_updown = r_ud; cfg_load = r_ld;
        cfg_tdr = r_tdr; cfg_div_val = r_div; int_en = r_ie; int_clr = r_ic;
        halt_req = r_hlt; ovf_trig = r_ovf; udf_trig = r_udf;
        e.row = row; e.cnt = ec; e.last = el;
        e.load = fl[2]; e.en = fl[1]; e.hack = fl[0]; e.tclr = {2{fl[2]}};
        e.ud = r_ud; e.ist = ist; e.irq = eirq;
        expq.push_back(e);
        row++;
        r_ld = 1'b0; r_ic = 2'b00; r_ovf = 1'b0; r_udf = 1'b0;
    endtask

    always @(negedge pclk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checks++;
            if ({cnt, last_cnt, load, en, updown, trig_clr, int_st, irq, halt_ack} !==
                {e.cnt, e.last, e.load, e.en, e.ud, e.tclr, e.ist, e.irq, e.hack}) begin
                errors++;
                $display("FAIL row%0d got cnt=%h last=%h ld=%b en=%b ud=%b tclr=%b ist=%b irq=%b hack=%b want cnt=%h last=%h ld=%b en=%b ud=%b tclr=%b ist=%b irq=%b hack=%b",
                         e.row, cnt, last_cnt, load, en, updown, trig_clr, int_st, irq, halt_ack,
                         e.cnt, e.last, e.load, e.en, e.ud, e.tclr, e.ist, e.irq, e.hack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        r_rst = 1'b1; r_en = 1'b0; r_ud = 1'b0; r_ld = 1'b0; r_hlt = 1'b0;
        r_ovf = 1'b0; r_udf = 1'b0; r_tdr = 8'h00; r_div = 4'h0; r_ie = 2'b00; r_ic = 2'b00;
        preset = 1'b1; cfg_en = 1'b0; cfg_updown = 1'b0; cfg_load = 1'b0; cfg_tdr = 8'h00;
        cfg_div_val = 4'h0; int_en = 2'b00; int_clr = 2'b00; halt_req = 1'b0;
        ovf_trig = 1'b0; udf_trig = 1'b0;

        // reset state
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);
        r_rst = 1'b0;
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);

        // up-count overflow from FD, div 0
        r_en = 1'b1; r_ld = 1'b1; r_tdr = 8'hFD; r_div = 4'h0; r_ie = 2'b01;
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);
        step(8'h00, 8'h00, LD,  2'b00, 1'b0);
        step(8'hFD, 8'hFD, RN,  2'b00, 1'b0);
        step(8'hFE, 8'hFD, RN,  2'b00, 1'b0);
        step(8'hFF, 8'hFE, RN,  2'b00, 1'b0);
        step(8'h00, 8'hFF, RN,  2'b00, 1'b0);
        r_ovf = 1'b1;
        step(8'h01, 8'h00, RN,  2'b00, 1'b0);
        step(8'h02, 8'h01, RN,  2'b01, 1'b1);
        r_ie = 2'b00;
        step(8'h03, 8'h02, RN,  2'b01, 1'b0);

        // clear coincident with set keeps status; clear alone drops it
        r_ie = 2'b01; r_ic = 2'b01; r_ovf = 1'b1;
        step(8'h04, 8'h03, RN,  2'b01, 1'b1);
        r_ic = 2'b01;
        step(8'h05, 8'h04, RN,  2'b01, 1'b1);
        step(8'h06, 8'h05, RN,  2'b00, 1'b0);

        // reload, then load 00 while at FF with a tick pending
        r_ld = 1'b1; r_tdr = 8'hFE;
        step(8'h07, 8'h06, RN,  2'b00, 1'b0);
        step(8'h08, 8'h07, LD,  2'b00, 1'b0);
        step(8'hFE, 8'hFE, RN,  2'b00, 1'b0);
        r_ld = 1'b1; r_tdr = 8'h00;
        step(8'hFF, 8'hFE, RN,  2'b00, 1'b0);
        r_ovf = 1'b1;
        step(8'h00, 8'hFF, LD,  2'b00, 1'b0);
        step(8'h00, 8'h00, RN,  2'b00, 1'b0);
        r_en = 1'b0;
        step(8'h01, 8'h00, RN,  2'b00, 1'b0);
        step(8'h02, 8'h01, IDL, 2'b00, 1'b0);
        step(8'h02, 8'h02, IDL, 2'b00, 1'b0);

        // down-count underflow from 02, div 3
        r_ld = 1'b1; r_tdr = 8'h02; r_ud = 1'b1; r_div = 4'h3; r_en = 1'b1; r_ie = 2'b10;
        step(8'h02, 8'h02, IDL, 2'b00, 1'b0);
        step(8'h02, 8'h02, LD,  2'b00, 1'b0);
        repeat (4) step(8'h02, 8'h02, RN, 2'b00, 1'b0);
        step(8'h01, 8'h02, RN,  2'b00, 1'b0);
        repeat (3) step(8'h01, 8'h01, RN, 2'b00, 1'b0);
        step(8'h00, 8'h01, RN,  2'b00, 1'b0);
        repeat (3) step(8'h00, 8'h00, RN, 2'b00, 1'b0);
        step(8'hFF, 8'h00, RN,  2'b00, 1'b0);
        r_udf = 1'b1;
        step(8'hFF, 8'hFF, RN,  2'b00, 1'b0);
        step(8'hFF, 8'hFF, RN,  2'b10, 1'b1);
        step(8'hFF, 8'hFF, RN,  2'b10, 1'b1);
        r_en = 1'b0;
        step(8'hFE, 8'hFF, RN,  2'b10, 1'b1);
        step(8'hFE, 8'hFE, IDL, 2'b10, 1'b1);
        r_ic = 2'b10;
        step(8'hFE, 8'hFE, IDL, 2'b10, 1'b1);
        step(8'hFE, 8'hFE, IDL, 2'b00, 1'b0);

        // debug halt at cnt 10, div 2
        r_ld = 1'b1; r_tdr = 8'h10; r_ud = 1'b0; r_div = 4'h2; r_en = 1'b1;
        step(8'hFE, 8'hFE, IDL, 2'b00, 1'b0);
        step(8'hFE, 8'hFE, LD,  2'b00, 1'b0);
        step(8'h10, 8'h10, RN,  2'b00, 1'b0);
        r_hlt = 1'b1;
        step(8'h10, 8'h10, RN,  2'b00, 1'b0);
`ifdef TIMER_HALT_EN
        step(8'h10, 8'h10, HT,  2'b00, 1'b0);
        step(8'h10, 8'h10, HT,  2'b00, 1'b0);
        r_hlt = 1'b0;
        step(8'h10, 8'h10, HT,  2'b00, 1'b0);
        step(8'h10, 8'h10, RN,  2'b00, 1'b0);
        step(8'h11, 8'h10, RN,  2'b00, 1'b0);
`else
        step(8'h10, 8'h10, RN,  2'b00, 1'b0);
        step(8'h11, 8'h10, RN,  2'b00, 1'b0);
        r_hlt = 1'b0;
        step(8'h11, 8'h11, RN,  2'b00, 1'b0);
        step(8'h11, 8'h11, RN,  2'b00, 1'b0);
        step(8'h12, 8'h11, RN,  2'b00, 1'b0);
`endif

        // async reset mid-run at 7F with both status bits set
        r_ld = 1'b1; r_tdr = 8'h7F; r_div = 4'h3; r_ovf = 1'b1; r_udf = 1'b1; r_ie = 2'b11;
        step(CST,   CST,   RN,  2'b00, 1'b0);
        step(CST,   CST,   LD,  2'b11, 1'b1);
        step(8'h7F, 8'h7F, RN,  2'b11, 1'b1);
        r_rst = 1'b1; r_en = 1'b0;
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);
        r_rst = 1'b0;
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);
        r_en = 1'b1;
        step(8'h00, 8'h00, IDL, 2'b00, 1'b0);
        step(8'h00, 8'h00, RN,  2'b00, 1'b0);
        step(8'h00, 8'h00, RN,  2'b00, 1'b0);

        // div_val lowered below div_cnt (2 -> 1): wraps through 16 states before ticking
        r_div = 4'h1;
        repeat (16) step(8'h00, 8'h00, RN, 2'b00, 1'b0);
        step(8'h01, 8'h00, RN,  2'b00, 1'b0);

        repeat (2) @(posedge pclk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
